// File: rtl/sr_cmd_conditioner.sv
// Turns two raw, bouncy set/clear button lines into clean single-cycle s/r commands for an SR flip-flop.
// Latency: a press first sampled at edge k gives s/r in the cycle after edge k+DEBOUNCE_CYCLES+3 when idle.
// No backpressure: requests that arrive while busy are discarded and reported on dropped.
module sr_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter bit CLR_PRIORITY    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s,
    output logic r,
    output logic busy,
    output logic q_expected,
    output logic conflict,
    output logic dropped
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LK_INIT = LW'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LOCKOUT
    } state_t;

    // Channel 0 is set, channel 1 is clear.
    logic [1:0]    btn;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    lvl;
    logic [1:0]    lvl_d;
    logic [1:0]    req;
    logic [CW-1:0] db_cnt [2];

    state_t        state;
    state_t        state_nx;
    logic [LW-1:0] lk_cnt;
    logic [LW-1:0] lk_nx;
    logic          s_nx;
    logic          r_nx;
    logic          q_nx;
    logic          conf_nx;
    logic          drop_nx;

    assign btn = {clr_btn, set_btn};

    // Synchronise, debounce and edge-detect both button channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            lvl    <= '0;
            lvl_d  <= '0;
            req    <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            lvl_d <= lvl;
            // Only a 0->1 change of the clean level is a request; releases are silent.
            req   <= lvl & ~lvl_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != lvl[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        lvl[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Command FSM: issue one pulse, then hold off new requests for the lockout window.
    always_comb begin
        state_nx = state;
        lk_nx    = lk_cnt;
        s_nx     = 1'b0;
        r_nx     = 1'b0;
        q_nx     = q_expected;
        conf_nx  = 1'b0;
        drop_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (req[0] && req[1]) begin
                    conf_nx  = 1'b1;
                    state_nx = ISSUE;
                    if (CLR_PRIORITY) begin
                        r_nx = 1'b1;
                        q_nx = 1'b0;
                    end else begin
                        s_nx = 1'b1;
                        q_nx = 1'b1;
                    end
                end else if (req[0]) begin
                    s_nx     = 1'b1;
                    q_nx     = 1'b1;
                    state_nx = ISSUE;
                end else if (req[1]) begin
                    r_nx     = 1'b1;
                    q_nx     = 1'b0;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                drop_nx = |req;
                if (LOCKOUT_CYCLES == 0) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = LOCKOUT;
                    lk_nx    = LK_INIT;
                end
            end
            LOCKOUT: begin
                drop_nx = |req;
                if (lk_cnt <= LW'(1)) begin
                    state_nx = IDLE;
                    lk_nx    = '0;
                end else begin
                    lk_nx = lk_cnt - LW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                lk_nx    = '0;
            end
        endcase
    end

    // State and registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lk_cnt     <= '0;
            s          <= 1'b0;
            r          <= 1'b0;
            q_expected <= 1'b0;
            conflict   <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            state      <= state_nx;
            lk_cnt     <= lk_nx;
            s          <= s_nx;
            r          <= r_nx;
            q_expected <= q_nx;
            conflict   <= conf_nx;
            dropped    <= drop_nx;
        end
    end

    assign busy = (state != IDLE);

    // The flip-flop must never see 11, nor two commands back to back.
    a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(s && r));
    a_no_repeat:  assert property (@(posedge clk) disable iff (rst) (s || r) |=> !(s || r));

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Bench for sr_cmd_conditioner: two instances (clear-wins and set-wins) share stimulus.
// Expected outputs come from a rule-level model: windowed debounce, rising-edge requests, busy-until arithmetic.
// Directed scenarios plus a randomized run; every cycle compared after the clock edge.
module tb_sr_cmd_conditioner;

    localparam int D = 4;
    localparam int L = 8;
    localparam logic [31:0] MASK = (32'd1 << D) - 32'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_btn = 1'b0;
    logic clr_btn = 1'b0;

    logic s_a, r_a, busy_a, q_a, conf_a, drop_a;
    logic s_b, r_b, busy_b, q_b, conf_b, drop_b;

    int total = 0;
    int bad = 0;

    sr_cmd_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .CLR_PRIORITY(1'b1)) u_a (
        .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
        .s(s_a), .r(r_a), .busy(busy_a), .q_expected(q_a), .conflict(conf_a), .dropped(drop_a)
    );

    sr_cmd_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .CLR_PRIORITY(1'b0)) u_b (
        .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
        .s(s_b), .r(r_b), .busy(busy_b), .q_expected(q_b), .conflict(conf_b), .dropped(drop_b)
    );

    always #5 clk = ~clk;

    // Reference model state. Index 0 = set channel, 1 = clear channel.
    // Model instance k=0 follows clear-wins, k=1 follows set-wins.
    int          cyc = 0;
    int          nie = 0;      // state is idle after any edge >= nie
    bit          m_s1 [2];
    bit          m_s2 [2];
    bit          m_lvl [2];
    bit          m_lvld [2];
    bit          m_req [2];
    logic [31:0] hist [2];
    int          hist_n [2];
    bit          e_s [2];
    bit          e_r [2];
    bit          e_q [2];
    bit          e_conf [2];
    bit          e_drop;
    bit          e_busy;

    task automatic model_edge();
        bit idle;
        bit any;
        bit both;
        bit clr_wins;
        bit b [2];
        cyc++;
        b[0] = set_btn;
        b[1] = clr_btn;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_lvld[c] = 0; m_req[c] = 0;
                hist[c] = '0; hist_n[c] = 0;
                e_s[c] = 0; e_r[c] = 0; e_q[c] = 0; e_conf[c] = 0;
            end
            e_drop = 0;
            e_busy = 0;
            nie = cyc;
            return;
        end
        idle = (cyc - 1 >= nie);
        any  = m_req[0] | m_req[1];
        both = m_req[0] & m_req[1];
        for (int k = 0; k < 2; k++) begin
            e_s[k] = 0; e_r[k] = 0; e_conf[k] = 0;
        end
        if (idle && any) begin
            for (int k = 0; k < 2; k++) begin
                clr_wins  = both ? (k == 0) : m_req[1];
                e_conf[k] = both;
                e_s[k]    = !clr_wins;
                e_r[k]    = clr_wins;
                e_q[k]    = !clr_wins;
            end
            nie = cyc + L + 1;
        end
        e_drop = any && !idle;
        e_busy = (cyc < nie);
        for (int c = 0; c < 2; c++) begin
            m_req[c]  = m_lvl[c] & ~m_lvld[c];
            m_lvld[c] = m_lvl[c];
            hist[c]   = {hist[c][30:0], m_s2[c]};
            if (hist_n[c] < 32) hist_n[c]++;
            // The clean level flips once the last D synchronised samples all disagree with it.
            if (hist_n[c] >= D && ((hist[c] ^ {32{m_lvl[c]}}) & MASK) == MASK)
                m_lvl[c] = ~m_lvl[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = b[c];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [11:0] obs();
        return {s_a, r_a, q_a, conf_a, drop_a, busy_a, s_b, r_b, q_b, conf_b, drop_b, busy_b};
    endfunction

    function automatic logic [11:0] expv();
        return {e_s[0], e_r[0], e_q[0], e_conf[0], e_drop, e_busy,
                e_s[1], e_r[1], e_q[1], e_conf[1], e_drop, e_busy};
    endfunction

    task automatic test_reset();
        rst = 1'b1; set_btn = 1'b0; clr_btn = 1'b0;
        step(); step();
        total++;
        if (obs() !== 12'b0) begin
            bad++; $display("FAIL reset_state cyc=%0d got=%b want=%b", cyc, obs(), 12'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (obs() !== 12'b0 || obs() !== expv()) begin
                bad++; $display("FAIL idle_quiet cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_set_latency();
        int k;
        int first_s = -1;
        int nbusy = 0;
        int ns = 0;
        set_btn = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 30; i++) begin
            step();
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL set_model cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
            if (s_a === 1'b1) begin
                ns++;
                if (first_s < 0) first_s = cyc;
            end
            if (busy_a === 1'b1) nbusy++;
        end
        total++;
        if (first_s != k + D + 3) begin
            bad++; $display("FAIL set_latency got=%0d want=%0d", first_s, k + D + 3);
        end
        total++;
        if (nbusy != L + 1 || ns != 1) begin
            bad++; $display("FAIL set_busy_len busy=%0d want=%0d spulses=%0d want=1", nbusy, L + 1, ns);
        end
        total++;
        if (q_a !== 1'b1) begin
            bad++; $display("FAIL set_q got=%b want=1", q_a);
        end
        set_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL set_release cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_glitch();
        int nr = 0;
        clr_btn = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 3) clr_btn = 1'b0;
            step();
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL glitch_model cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
            if (r_a === 1'b1 || r_b === 1'b1 || busy_a === 1'b1) nr++;
        end
        total++;
        if (nr != 0 || q_a !== 1'b1) begin
            bad++; $display("FAIL glitch_filtered activity=%0d want=0 q=%b want=1", nr, q_a);
        end
    endtask

    task automatic test_conflict();
        bit seen_a = 0;
        bit seen_b = 0;
        bit wrong = 0;
        set_btn = 1'b1; clr_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL conflict_model cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
            if (r_a === 1'b1 && conf_a === 1'b1) seen_a = 1;
            if (s_b === 1'b1 && conf_b === 1'b1) seen_b = 1;
            if (s_a === 1'b1 || r_b === 1'b1) wrong = 1;
        end
        total++;
        if (!seen_a || !seen_b || wrong || q_a !== 1'b0 || q_b !== 1'b1) begin
            bad++; $display("FAIL conflict_winner clr_wins_seen=%b set_wins_seen=%b loser=%b qa=%b qb=%b want 1 1 0 0 1",
                            seen_a, seen_b, wrong, q_a, q_b);
        end
        set_btn = 1'b0; clr_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL conflict_release cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_dropped();
        int guard = 0;
        int nd = 0;
        int nr = 0;
        set_btn = 1'b1;
        while (s_a !== 1'b1 && guard < 20) begin
            step();
            guard++;
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL drop_setup cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
        end
        total++;
        if (s_a !== 1'b1) begin
            bad++; $display("FAIL drop_set_timeout got=%b want=1", s_a);
        end
        set_btn = 1'b0; clr_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL drop_model cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
            if (drop_a === 1'b1) nd++;
            if (r_a === 1'b1) nr++;
        end
        total++;
        if (nd != 1 || nr != 0 || q_a !== 1'b1) begin
            bad++; $display("FAIL drop_pulse drops=%0d want=1 r=%0d want=0 q=%b want=1", nd, nr, q_a);
        end
        clr_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL drop_release cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
        end
        clr_btn = 1'b1;
        nr = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL drop_repress cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
            if (r_a === 1'b1) nr++;
        end
        total++;
        if (nr != 1 || q_a !== 1'b0) begin
            bad++; $display("FAIL drop_repress_r r=%0d want=1 q=%b want=0", nr, q_a);
        end
        clr_btn = 1'b0;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_reset_during_issue();
        int guard = 0;
        int k;
        int first_s = -1;
        set_btn = 1'b1;
        while (s_a !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        total++;
        if (s_a !== 1'b1) begin
            bad++; $display("FAIL rst_issue_timeout got=%b want=1", s_a);
        end
        rst = 1'b1;
        step();
        total++;
        if (obs() !== 12'b0 || obs() !== expv()) begin
            bad++; $display("FAIL rst_issue_clear got=%b want=%b", obs(), 12'b0);
        end
        rst = 1'b0;
        k = cyc + 1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL rst_issue_model cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
            if (s_a === 1'b1 && first_s < 0) first_s = cyc;
        end
        total++;
        if (first_s != k + D + 3) begin
            bad++; $display("FAIL rst_issue_relatency got=%0d want=%0d", first_s, k + D + 3);
        end
        set_btn = 1'b0;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_random();
        int hold0 = 0;
        int hold1 = 0;
        int errs = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold0 == 0) begin
                set_btn = 1'($urandom_range(0, 1));
                hold0 = $urandom_range(1, 12);
            end else begin
                hold0--;
            end
            if (hold1 == 0) begin
                clr_btn = 1'($urandom_range(0, 1));
                hold1 = $urandom_range(1, 12);
            end else begin
                hold1--;
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
            total++;
            if (obs() !== expv()) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, obs(), expv());
            end
        end
        rst = 1'b0; set_btn = 1'b0; clr_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_set_latency();
        test_glitch();
        test_conflict();
        test_dropped();
        test_reset_during_issue();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
